// File: rtl/pcid_tlb.sv
// pcid_tlb: 8-way set-associative TLB tagged by PCID,
// tree-PLRU replacement, 64-bit hit/miss/insert counters.
module pcid_tlb #(
    parameter int SET_BITS   = 3,
    parameter int PAGE_SHIFT = 12
) (
    input  logic        clk,
    input  logic        shutdown,
    input  logic        insert,
    input  logic [63:0] va,
    input  logic [63:0] pa,
    input  logic [11:0] pcid,
    output logic [63:0] o_addr,
    output logic        hit,
    output logic        miss,
    output logic [63:0] stat_hit,
    output logic [63:0] stat_miss,
    output logic [63:0] stat_prefetch
);

    localparam int SETS  = 1 << SET_BITS;
    localparam int WAYS  = 8;
    localparam int TAG_W = 64 - PAGE_SHIFT - SET_BITS;
    localparam int PPN_W = 64 - PAGE_SHIFT;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [6:0]       plru_q  [SETS];
    logic [11:0]      pcid_q  [SETS][WAYS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [PPN_W-1:0] ppn_q   [SETS][WAYS];

    logic [SET_BITS-1:0] set_idx;
    logic [TAG_W-1:0]    va_tag;
    logic [WAYS-1:0]     match_vec;
    logic                any_match;
    logic                all_valid;
    logic [2:0]          match_way;
    logic [2:0]          free_way;
    logic [2:0]          tgt_way;
    logic [2:0]          acc_way;
    logic [6:0]          plru_nxt;
    logic                lk_hit;
    logic                lk_miss;

    // Bit 0 is the root; a 0 bit steers the victim to the lower half.
    function automatic logic [2:0] plru_victim(input logic [6:0] t);
        logic       b0;
        logic       b1;
        logic       b2;
        logic [1:0] p;
        b0 = t[0];
        b1 = b0 ? t[2] : t[1];
        p  = {b0, b1};
        b2 = t[3 + int'(p)];
        return {b0, b1, b2};
    endfunction

    function automatic logic [6:0] plru_touch(
        input logic [6:0] t,
        input logic [2:0] w
    );
        logic [6:0] n;
        n    = t;
        n[0] = ~w[2];
        if (w[2]) n[2] = ~w[1];
        else      n[1] = ~w[1];
        n[3 + int'(w[2:1])] = ~w[0];
        return n;
    endfunction

    assign set_idx = va[PAGE_SHIFT+SET_BITS-1:PAGE_SHIFT];
    assign va_tag  = va[63:PAGE_SHIFT+SET_BITS];

    always_comb begin
        match_vec = '0;
        match_way = '0;
        free_way  = '0;
        for (int w = 0; w < WAYS; w++) begin
            match_vec[w] = valid_q[set_idx][w]
                         && (tag_q[set_idx][w] == va_tag)
                         && (pcid_q[set_idx][w] == pcid);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match_vec[w])         match_way = 3'(w);
            if (!valid_q[set_idx][w]) free_way  = 3'(w);
        end
    end

    assign any_match = |match_vec;
    assign all_valid = &valid_q[set_idx];
    assign lk_hit    = !insert && any_match;
    assign lk_miss   = !insert && !any_match;

    // Refill hits overwrite in place; otherwise fill holes before evicting.
    always_comb begin
        tgt_way = plru_victim(plru_q[set_idx]);
        if (any_match)       tgt_way = match_way;
        else if (!all_valid) tgt_way = free_way;
        acc_way  = insert ? tgt_way : match_way;
        plru_nxt = plru_touch(plru_q[set_idx], acc_way);
    end

    always_ff @(posedge clk or posedge shutdown) begin
        if (shutdown) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            hit           <= 1'b0;
            miss          <= 1'b0;
            o_addr        <= '0;
            stat_hit      <= '0;
            stat_miss     <= '0;
            stat_prefetch <= '0;
        end else begin
            hit    <= lk_hit;
            miss   <= lk_miss;
            o_addr <= lk_hit
                ? {ppn_q[set_idx][match_way], va[PAGE_SHIFT-1:0]}
                : '0;
            if (insert) begin
                valid_q[set_idx][tgt_way] <= 1'b1;
                stat_prefetch <= stat_prefetch + 64'd1;
            end
            if (insert || any_match) plru_q[set_idx] <= plru_nxt;
            if (lk_hit)  stat_hit  <= stat_hit + 64'd1;
            if (lk_miss) stat_miss <= stat_miss + 64'd1;
        end
    end

    // Entry payload needs no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (insert) begin
            pcid_q[set_idx][tgt_way] <= pcid;
            tag_q[set_idx][tgt_way]  <= va_tag;
            ppn_q[set_idx][tgt_way]  <= pa[63:PAGE_SHIFT];
        end
    end

endmodule

// File: tb/tb_pcid_tlb.sv
// tb_pcid_tlb: directed bench for pcid_tlb with
// hand-computed expectations and immediate assertions.
module tb_pcid_tlb;

    logic        clk;
    logic        shutdown;
    logic        insert;
    logic [63:0] va;
    logic [63:0] pa;
    logic [11:0] pcid;
    logic [63:0] o_addr;
    logic        hit;
    logic        miss;
    logic [63:0] stat_hit;
    logic [63:0] stat_miss;
    logic [63:0] stat_prefetch;

    int checks;
    int passed;
    logic [63:0] exp_hit;
    logic [63:0] exp_miss;
    logic [63:0] exp_pf;

    pcid_tlb dut (
        .clk(clk),
        .shutdown(shutdown),
        .insert(insert),
        .va(va),
        .pa(pa),
        .pcid(pcid),
        .o_addr(o_addr),
        .hit(hit),
        .miss(miss),
        .stat_hit(stat_hit),
        .stat_miss(stat_miss),
        .stat_prefetch(stat_prefetch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       name,
        input logic [63:0] obs,
        input logic [63:0] exp
    );
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s got=%h exp=%h", name, obs, exp);
    endtask

    task automatic chk_stats(input string name);
        chk({name, ".stat_hit"}, stat_hit, exp_hit);
        chk({name, ".stat_miss"}, stat_miss, exp_miss);
        chk({name, ".stat_prefetch"}, stat_prefetch, exp_pf);
    endtask

    task automatic do_insert(
        input string       name,
        input logic [63:0] a,
        input logic [63:0] p,
        input logic [11:0] id
    );
        insert = 1'b1;
        va     = a;
        pa     = p;
        pcid   = id;
        @(posedge clk);
        #1;
        exp_pf++;
        chk({name, ".hit"}, 64'(hit), 64'd0);
        chk({name, ".miss"}, 64'(miss), 64'd0);
        chk({name, ".o_addr"}, o_addr, 64'd0);
        chk({name, ".stat_prefetch"}, stat_prefetch, exp_pf);
    endtask

    task automatic do_lookup(
        input string       name,
        input logic [63:0] a,
        input logic [11:0] id,
        input logic        exp_h,
        input logic [63:0] exp_a
    );
        insert = 1'b0;
        va     = a;
        pa     = '0;
        pcid   = id;
        @(posedge clk);
        #1;
        if (exp_h) exp_hit++;
        else       exp_miss++;
        chk({name, ".hit"}, 64'(hit), 64'(exp_h));
        chk({name, ".miss"}, 64'(miss), 64'(!exp_h));
        chk({name, ".o_addr"}, o_addr, exp_a);
        chk({name, ".stat_hit"}, stat_hit, exp_hit);
        chk({name, ".stat_miss"}, stat_miss, exp_miss);
    endtask

    function automatic logic [63:0] s0_va(input int i, input int off);
        return (64'(i + 1) << 15) | 64'(off);
    endfunction

    function automatic logic [63:0] s0_pa(input int i);
        return 64'(32'h100 + i) << 12;
    endfunction

    localparam logic [63:0] VA_HI = 64'hFFFF_FFFF_FFFF_FFF1;

    initial begin
        checks   = 0;
        passed   = 0;
        exp_hit  = '0;
        exp_miss = '0;
        exp_pf   = '0;
        shutdown = 1'b0;
        insert   = 1'b0;
        va       = '0;
        pa       = '0;
        pcid     = '0;

        // Asynchronous reset, asserted mid-cycle.
        #2 shutdown = 1'b1;
        #1;
        chk("rst.hit", 64'(hit), 64'd0);
        chk("rst.miss", 64'(miss), 64'd0);
        chk("rst.o_addr", o_addr, 64'd0);
        chk_stats("rst");
        @(posedge clk);
        #1 shutdown = 1'b0;

        do_lookup("empty", 64'd0, 12'd0, 1'b0, 64'd0);

        do_insert("ins_hi0", VA_HI, 64'd0, 12'd0);
        do_insert("ins_hi1", VA_HI, 64'd0, 12'd0);
        chk("ins_hi.pf2", stat_prefetch, 64'd2);
        do_lookup("lk_hi", VA_HI, 12'd0, 1'b1, 64'h0FF1);

        // Same VA under another PCID is a different entry.
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 5; c++) begin
                if (ph[0] == 1'b0)
                    do_lookup("pcid1", VA_HI, 12'd1, 1'b0, 64'd0);
                else
                    do_lookup("pcid0", VA_HI, 12'd0, 1'b1, 64'h0FF1);
            end
        end
        chk("iso.stat_hit", stat_hit, 64'd11);
        chk("iso.stat_miss", stat_miss, 64'd11);

        for (int i = 0; i < 8; i++)
            do_insert("fill", s0_va(i, 0), s0_pa(i), 12'd0);
        for (int i = 0; i < 8; i++)
            do_lookup("fill_lk", s0_va(i, 12'h123), 12'd0,
                      1'b1, s0_pa(i) | 64'h123);

        do_lookup("t0_hit", s0_va(0, 12'h004), 12'd0,
                  1'b1, s0_pa(0) | 64'h004);
        do_insert("t8", s0_va(8, 0), s0_pa(8), 12'd0);
        do_lookup("t0_kept", s0_va(0, 12'hFFF), 12'd0,
                  1'b1, s0_pa(0) | 64'hFFF);
        do_lookup("t4_evict", s0_va(4, 12'h010), 12'd0,
                  1'b0, 64'd0);
        do_lookup("t8_hit", s0_va(8, 12'h010), 12'd0,
                  1'b1, s0_pa(8) | 64'h010);
        do_lookup("t5_kept", s0_va(5, 12'h020), 12'd0,
                  1'b1, s0_pa(5) | 64'h020);

        do_insert("ovw", s0_va(0, 0), 64'h5000, 12'd0);
        do_lookup("ovw_lk", s0_va(0, 12'hABC), 12'd0,
                  1'b1, 64'h5ABC);
        for (int i = 1; i < 9; i++) begin
            if (i != 4)
                do_lookup("ovw_keep", s0_va(i, 12'h7), 12'd0,
                          1'b1, s0_pa(i) | 64'h7);
        end
        chk("end.pf", stat_prefetch, 64'd12);

        // Second reset mid-cycle wipes entries and counters.
        #3 shutdown = 1'b1;
        #1;
        exp_hit  = '0;
        exp_miss = '0;
        exp_pf   = '0;
        chk("rst2.hit", 64'(hit), 64'd0);
        chk("rst2.o_addr", o_addr, 64'd0);
        chk_stats("rst2");
        @(posedge clk);
        #1 shutdown = 1'b0;
        do_lookup("rst2_t1", s0_va(1, 0), 12'd0, 1'b0, 64'd0);
        do_lookup("rst2_hi", VA_HI, 12'd0, 1'b0, 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pcid_tlb.md
Name: pcid_tlb

Overview:
- 8-way set-associative translation lookaside buffer with PCID tagging, tree-PLRU replacement and 64-bit hit/miss/insert statistics counters.
- Sits between the core's address-generation stage and the page-table walker.
- Translates a 64-bit virtual address (VA) to a physical address (PA) for the current PCID.
- Entries are filled by explicit insert requests from the walker.

Parameters:
- SET_BITS, 3, log2 of number of sets (8 sets); power-of-two set count.
- PAGE_SHIFT, 12, page-offset width (4 KiB pages).
- Way count is fixed at 8 (7-bit PLRU tree per set); not a parameter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- shutdown  in  1  reset, asynchronous, active-high.
- insert  in  1  fill request; write {va, pa, pcid} entry this cycle.
- va  in  64  virtual address for lookup/insert.
- pa  in  64  physical address for insert (page number taken from pa[63:PAGE_SHIFT]).
- pcid  in  12  process-context ID for lookup/insert.
- o_addr  out  64  translated PA = {stored PPN, va[PAGE_SHIFT-1:0]}; 0 when not hit.
- hit  out  1  registered: lookup hit.
- miss  out  1  registered: lookup miss.
- stat_hit  out  64  number of cycles hit was asserted.
- stat_miss  out  64  number of cycles miss was asserted.
- stat_prefetch  out  64  number of insert operations performed.

Behaviour:
- Address split:
  - set index = va[PAGE_SHIFT+SET_BITS-1:PAGE_SHIFT].
  - tag = va[63:PAGE_SHIFT+SET_BITS] (49 bits at defaults).
  - offset = va[PAGE_SHIFT-1:0].
- Entry fields: valid, pcid[11:0], tag, ppn[63-PAGE_SHIFT:0].
- A match requires valid AND equal tag AND equal pcid; the same VA under a different PCID is a distinct entry.
- Reset (shutdown=1, asynchronous):
  - clears all valid bits and all PLRU bits.
  - clears hit, miss, o_addr and all three counters to 0.
  - Held while asserted; normal operation resumes on the first rising edge after deassertion.
- Lookup (insert=0), one-cycle latency:
  - At a rising edge, the set is searched with the current va/pcid; hit/miss/o_addr are registered and valid after that edge.
  - Exactly one of hit/miss is 1.
  - On hit: o_addr = {ppn, va offset}, and the set's PLRU is updated to point away from the hit way.
  - On miss: o_addr = 0; PLRU unchanged.
  - Lookups repeat every cycle while inputs are held; results track the inputs each cycle.
- Insert (insert=1), at the rising edge:
  - If a matching entry exists (same set/tag/pcid), its ppn is overwritten in place.
  - Otherwise the victim is the lowest-index invalid way; if all 8 ways are valid, the victim is the PLRU way.
  - The written way becomes MRU (PLRU updated away from it).
  - That cycle hit=0, miss=0, o_addr=0; no lookup is performed.
  - stat_prefetch increments once per insert cycle. A multi-cycle held insert rewrites the same entry each cycle and counts each cycle.
- PLRU tree, per set, 7 bits:
  - bit0 is the root; bit1/bit2 sit at level 2; bits 3..6 are leaves over way pairs.
  - Bit value 0 means the victim lies in the lower half.
  - On access, every bit on the path is set to point to the other half.
  - All-zero state selects way 0.
- Counters:
  - stat_hit increments on every edge where the registered hit becomes 1; stat_miss likewise for miss.
  - Counters wrap modulo 2^64.
- No invalidate/flush port other than shutdown.

Test Plan:
- Reset: pulse shutdown mid-cycle -> immediately hit=0, miss=0, o_addr=0, all stats=0, all entries invalid.
- Insert then lookup:
  - Insert va=0xFFFFFFFFFFFFFFF1, pa=0, pcid=0 for 2 cycles -> stat_prefetch=2.
  - Then lookup same va with pcid=0 -> hit=1, miss=0, o_addr=0x0000000000000FF1.
- PCID isolation: after the above, lookup the same va with pcid=1 -> miss=1, o_addr=0. Alternating pcid 1/0/1/0 every 5 cycles toggles miss/hit, and stat_hit/stat_miss count the corresponding cycles.
- Fill order: 8 inserts to set 0 with distinct tags -> ways 0..7 filled in order; all 8 then hit.
- PLRU eviction:
  - Fill set 0 with tags T0..T7, then hit T0.
  - A 9th insert T8 evicts the PLRU way (way 4 from the tree state), not way 0.
  - T0 still hits; the evicted tag misses.
- Overwrite: insert an existing va/pcid with a new pa=0x5000 -> no new way consumed; lookup returns o_addr=0x5000|offset.
